// File: rtl/life_pkg.sv
// Shared definitions for the life tile controller and its helpers.
// Contents:
//   state_t     - controller FSM states (IDLE, LOAD, CHECK, STEP, SETTLE, DONE)
//   TILE_DIM    - tile edge length (4)
//   TILE_CELLS  - cells per tile (16)
//   cell_idx    - bit index of column c, row r (row 0 = north)
package life_pkg;

  localparam int TILE_DIM   = 4;
  localparam int TILE_CELLS = TILE_DIM * TILE_DIM;
  localparam int CELL_IDX_W = $clog2(TILE_CELLS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    STEP   = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Columns are stored as contiguous nibbles: bit 4*c + r.
  function automatic logic [CELL_IDX_W-1:0] cell_idx(input int c, input int r);
    return CELL_IDX_W'(c * TILE_DIM + r);
  endfunction

endpackage

// File: rtl/life_tile_ctrl_if.sv
// Host-side handshake bundle of life_tile_ctrl.
// Parameter: GEN_W - width of the generation count fields.
// Signals:
//   cfg_valid/cfg_ready/cfg_pattern/cfg_gens           - config request
//   res_valid/res_ready/res_pattern/res_gens/res_stable - run result
// Modports: master = host/bus adapter, slave = controller.
interface life_tile_ctrl_if #(parameter int GEN_W = 16);
  import life_pkg::*;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [TILE_CELLS-1:0] cfg_pattern;
  logic [GEN_W-1:0]      cfg_gens;
  logic                  res_valid;
  logic                  res_ready;
  logic [TILE_CELLS-1:0] res_pattern;
  logic [GEN_W-1:0]      res_gens;
  logic                  res_stable;

  modport master (
    output cfg_valid, cfg_pattern, cfg_gens, res_ready,
    input  cfg_ready, res_valid, res_pattern, res_gens, res_stable
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_gens, res_ready,
    output cfg_ready, res_valid, res_pattern, res_gens, res_stable
  );

endinterface

// File: rtl/life_boundary_4x4.sv
// Edge/corner neighbour generator for one 4x4 life tile (purely combinational).
// Parameter: TORUS - 0: all boundary outputs are dead (0); 1: the tile wraps onto itself.
// Ports:
//   alive          in  16  current tile state, bit 4*c+r
//   n, e, s, w     out 4   edge neighbours (n/s indexed by column, e/w by row)
//   nw, ne, se, sw out 1   corner neighbours
module life_boundary_4x4
  import life_pkg::*;
#(
  parameter bit TORUS = 1'b0
) (
  input  logic [TILE_CELLS-1:0] alive,
  output logic [TILE_DIM-1:0]   n,
  output logic [TILE_DIM-1:0]   e,
  output logic [TILE_DIM-1:0]   s,
  output logic [TILE_DIM-1:0]   w,
  output logic                  nw,
  output logic                  ne,
  output logic                  se,
  output logic                  sw
);

  // Interior cells never reach the boundary, so not every bit is read.
  logic unused_alive;
  assign unused_alive = ^alive;

  generate
    if (TORUS) begin : g_torus
      // North of row 0 is row 3 and vice versa; west of column 0 is column 3.
      for (genvar gi = 0; gi < TILE_DIM; gi++) begin : g_edge
        assign n[gi] = alive[cell_idx(gi, TILE_DIM - 1)];
        assign s[gi] = alive[cell_idx(gi, 0)];
        assign w[gi] = alive[cell_idx(TILE_DIM - 1, gi)];
        assign e[gi] = alive[cell_idx(0, gi)];
      end
      assign nw = alive[cell_idx(TILE_DIM - 1, TILE_DIM - 1)];
      assign ne = alive[cell_idx(0, TILE_DIM - 1)];
      assign sw = alive[cell_idx(TILE_DIM - 1, 0)];
      assign se = alive[cell_idx(0, 0)];
    end else begin : g_dead
      assign n  = '0;
      assign e  = '0;
      assign s  = '0;
      assign w  = '0;
      assign nw = 1'b0;
      assign ne = 1'b0;
      assign se = 1'b0;
      assign sw = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/life_tile_ctrl.sv
// Controller for one life_array_4x4 tile: loads a seed, pulses step once per
// generation, and returns the final board and the number of generations run.
// Parameters: TORUS (boundary wrap), GEN_W (generation counter width).
// Optional feature macro: STABLE_STOP_EN - stop early when the board stops changing.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   bus                   life_tile_ctrl_if.slave (config + result handshakes)
//   busy                  high in every state except IDLE
//   arr_val/arr_write_enb seed write into the tile
//   arr_step              one-cycle generation pulse
//   arr_alive/arr_alive_prev tile state and its previous generation
//   arr_n/e/s/w, arr_nw/ne/se/sw  tile boundary neighbours
module life_tile_ctrl
  import life_pkg::*;
#(
  parameter bit TORUS = 1'b0,
  parameter int GEN_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  life_tile_ctrl_if.slave       bus,
  output logic                  busy,
  output logic [TILE_CELLS-1:0] arr_val,
  output logic                  arr_write_enb,
  output logic                  arr_step,
  input  logic [TILE_CELLS-1:0] arr_alive,
  input  logic [TILE_CELLS-1:0] arr_alive_prev,
  output logic                  arr_nw,
  output logic                  arr_ne,
  output logic                  arr_se,
  output logic                  arr_sw,
  output logic [TILE_DIM-1:0]   arr_n,
  output logic [TILE_DIM-1:0]   arr_e,
  output logic [TILE_DIM-1:0]   arr_s,
  output logic [TILE_DIM-1:0]   arr_w
);

  state_t                state_reg, state_next;
  logic [TILE_CELLS-1:0] pattern_reg;
  logic [GEN_W-1:0]      remaining_reg;
  logic [GEN_W-1:0]      gen_cnt_reg;
  logic [TILE_CELLS-1:0] res_pattern_reg;
  logic                  stop_hit;

`ifdef STABLE_STOP_EN
  logic stable_reg;
  // gen_cnt>=1 keeps the freshly written seed from being compared with stale history.
  assign stop_hit       = (gen_cnt_reg != '0) && (arr_alive == arr_alive_prev);
  assign bus.res_stable = stable_reg;
`else
  logic unused_prev;
  assign unused_prev    = ^arr_alive_prev;
  assign stop_hit       = 1'b0;
  assign bus.res_stable = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.cfg_ready = 1'b0;
    bus.res_valid = 1'b0;
    arr_write_enb = 1'b0;
    arr_step      = 1'b0;
    arr_val       = '0;
    busy          = 1'b1;
    case (state_reg)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        busy          = 1'b0;
        if (bus.cfg_valid) state_next = LOAD;
      end
      LOAD: begin
        arr_write_enb = 1'b1;
        arr_val       = pattern_reg;
        state_next    = CHECK;
      end
      CHECK: begin
        if (remaining_reg == '0 || stop_hit) state_next = DONE;
        else                                 state_next = STEP;
      end
      STEP: begin
        arr_step   = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: state_next = CHECK;
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_reg     <= '0;
      remaining_reg   <= '0;
      gen_cnt_reg     <= '0;
      res_pattern_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cfg_valid) begin
            pattern_reg   <= bus.cfg_pattern;
            remaining_reg <= bus.cfg_gens;
            gen_cnt_reg   <= '0;
          end
        end
        CHECK: begin
          if (state_next == DONE) res_pattern_reg <= arr_alive;
        end
        SETTLE: begin
          // Count the generation only after step has dropped, so the tile's toggle has cleared.
          if (remaining_reg != '0) remaining_reg <= remaining_reg - GEN_W'(1);
          if (gen_cnt_reg != '1)   gen_cnt_reg   <= gen_cnt_reg + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef STABLE_STOP_EN
  always_ff @(posedge clk) begin
    if (reset)                                    stable_reg <= 1'b0;
    else if (state_reg == IDLE && bus.cfg_valid)  stable_reg <= 1'b0;
    else if (state_reg == CHECK && stop_hit)      stable_reg <= 1'b1;
  end
`endif

  assign bus.res_pattern = res_pattern_reg;
  assign bus.res_gens    = gen_cnt_reg;

  life_boundary_4x4 #(.TORUS(TORUS)) u_boundary (
    .alive (arr_alive),
    .n     (arr_n),
    .e     (arr_e),
    .s     (arr_s),
    .w     (arr_w),
    .nw    (arr_nw),
    .ne    (arr_ne),
    .se    (arr_se),
    .sw    (arr_sw)
  );

endmodule

// File: tb/tb_life_tile_ctrl.sv
// Testbench for life_tile_ctrl: DUT 0 with TORUS=0, DUT 1 with TORUS=1, each
// driving a behavioural 4x4 life tile. Expected results are queued when a
// config is accepted and popped when the result handshake occurs.
module tb_life_tile_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int step_viol = 0;

  logic        cfg_valid [2];
  logic [15:0] cfg_pattern [2];
  logic [15:0] cfg_gens [2];
  logic        res_ready [2];
  logic        cfg_ready_o [2];
  logic        res_valid_o [2];
  logic        res_stable_o [2];
  logic [15:0] res_pattern_o [2];
  logic [15:0] res_gens_o [2];
  logic        busy_o [2];
  logic        we_o [2];
  logic        step_o [2];
  logic [15:0] val_o [2];
  logic [3:0]  n_o [2];
  logic [3:0]  e_o [2];
  logic [3:0]  s_o [2];
  logic [3:0]  w_o [2];
  logic        nw_o [2];
  logic        ne_o [2];
  logic        sw_o [2];
  logic        se_o [2];
  logic [15:0] alive0, alive1, prev0, prev1;

  typedef struct {
    logic [15:0] pat;
    logic [15:0] gens;
    logic        stable;
  } exp_t;
  exp_t sbq[$];

  life_tile_ctrl_if #(.GEN_W(16)) bus0 ();
  life_tile_ctrl_if #(.GEN_W(16)) bus1 ();

  assign bus0.cfg_valid   = cfg_valid[0];
  assign bus0.cfg_pattern = cfg_pattern[0];
  assign bus0.cfg_gens    = cfg_gens[0];
  assign bus0.res_ready   = res_ready[0];
  assign cfg_ready_o[0]   = bus0.cfg_ready;
  assign res_valid_o[0]   = bus0.res_valid;
  assign res_pattern_o[0] = bus0.res_pattern;
  assign res_gens_o[0]    = bus0.res_gens;
  assign res_stable_o[0]  = bus0.res_stable;
  assign bus1.cfg_valid   = cfg_valid[1];
  assign bus1.cfg_pattern = cfg_pattern[1];
  assign bus1.cfg_gens    = cfg_gens[1];
  assign bus1.res_ready   = res_ready[1];
  assign cfg_ready_o[1]   = bus1.cfg_ready;
  assign res_valid_o[1]   = bus1.res_valid;
  assign res_pattern_o[1] = bus1.res_pattern;
  assign res_gens_o[1]    = bus1.res_gens;
  assign res_stable_o[1]  = bus1.res_stable;

  life_tile_ctrl #(.TORUS(1'b0), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy_o[0]),
    .arr_val(val_o[0]), .arr_write_enb(we_o[0]), .arr_step(step_o[0]),
    .arr_alive(alive0), .arr_alive_prev(prev0),
    .arr_nw(nw_o[0]), .arr_ne(ne_o[0]), .arr_se(se_o[0]), .arr_sw(sw_o[0]),
    .arr_n(n_o[0]), .arr_e(e_o[0]), .arr_s(s_o[0]), .arr_w(w_o[0])
  );

  life_tile_ctrl #(.TORUS(1'b1), .GEN_W(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy_o[1]),
    .arr_val(val_o[1]), .arr_write_enb(we_o[1]), .arr_step(step_o[1]),
    .arr_alive(alive1), .arr_alive_prev(prev1),
    .arr_nw(nw_o[1]), .arr_ne(ne_o[1]), .arr_se(se_o[1]), .arr_sw(sw_o[1]),
    .arr_n(n_o[1]), .arr_e(e_o[1]), .arr_s(s_o[1]), .arr_w(w_o[1])
  );

  // Conway step of a 4x4 tile surrounded by its boundary inputs; grid is [col+1][row+1].
  function automatic logic [15:0] next_gen(input logic [15:0] a, input logic [3:0] n, e, s, w,
                                           input logic nw, ne, sw, se);
    logic g [0:5][0:5];
    logic [15:0] r;
    int cnt;
    for (int c = 0; c < 6; c++) for (int rr = 0; rr < 6; rr++) g[c][rr] = 1'b0;
    for (int c = 0; c < 4; c++) for (int rr = 0; rr < 4; rr++) g[c+1][rr+1] = a[4*c+rr];
    for (int i = 0; i < 4; i++) begin
      g[i+1][0] = n[i];
      g[i+1][5] = s[i];
      g[0][i+1] = w[i];
      g[5][i+1] = e[i];
    end
    g[0][0] = nw; g[5][0] = ne; g[0][5] = sw; g[5][5] = se;
    r = '0;
    for (int c = 1; c < 5; c++) begin
      for (int rr = 1; rr < 5; rr++) begin
        cnt = 0;
        for (int dc = -1; dc <= 1; dc++)
          for (int dr = -1; dr <= 1; dr++)
            if ((dc != 0 || dr != 0) && g[c+dc][rr+dr]) cnt++;
        r[4*(c-1)+(rr-1)] = (cnt == 3) || (g[c][rr] && cnt == 2);
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      alive0 <= '0; prev0 <= '0;
    end else if (we_o[0]) begin
      alive0 <= val_o[0]; prev0 <= val_o[0];
    end else if (step_o[0]) begin
      prev0  <= alive0;
      alive0 <= next_gen(alive0, n_o[0], e_o[0], s_o[0], w_o[0], nw_o[0], ne_o[0], sw_o[0], se_o[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alive1 <= '0; prev1 <= '0;
    end else if (we_o[1]) begin
      alive1 <= val_o[1]; prev1 <= val_o[1];
    end else if (step_o[1]) begin
      prev1  <= alive1;
      alive1 <= next_gen(alive1, n_o[1], e_o[1], s_o[1], w_o[1], nw_o[1], ne_o[1], sw_o[1], se_o[1]);
    end
  end

  // Step pulse rules: never on consecutive cycles, never together with a write.
  logic prev_step [2];
  initial begin prev_step[0] = 1'b0; prev_step[1] = 1'b0; end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (step_o[d] === 1'b1 && prev_step[d] === 1'b1) step_viol++;
      if (step_o[d] === 1'b1 && we_o[d] === 1'b1) step_viol++;
      prev_step[d] = step_o[d];
    end
  end

  task automatic start_cfg(input int d, input logic [15:0] pat, input logic [15:0] gens,
                           input logic [15:0] ep, input logic [15:0] eg, input logic es);
    exp_t e;
    @(negedge clk);
    tests_run++;
    if (cfg_ready_o[d] !== 1'b1) begin
      tests_failed++;
      $display("FAIL cfg_ready_idle dut%0d: got %b want 1", d, cfg_ready_o[d]);
    end
    cfg_pattern[d] = pat;
    cfg_gens[d]    = gens;
    cfg_valid[d]   = 1'b1;
    @(posedge clk);
    e.pat = ep; e.gens = eg; e.stable = es;
    sbq.push_back(e);
    #1 cfg_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int cycles, output bit ok);
    cycles = 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (res_valid_o[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      cycles++;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL res_valid_timeout dut%0d: no res_valid within 200 cycles", d);
    end
  endtask

  task automatic check_result(input int d, input string name);
    exp_t e;
    tests_run++;
    if (sbq.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_sb_empty: result with no expected entry", name);
      return;
    end
    e = sbq.pop_front();
    if (res_pattern_o[d] !== e.pat) begin
      tests_failed++;
      $display("FAIL %s_pattern: got %h want %h", name, res_pattern_o[d], e.pat);
    end
    tests_run++;
    if (res_gens_o[d] !== e.gens) begin
      tests_failed++;
      $display("FAIL %s_gens: got %0d want %0d", name, res_gens_o[d], e.gens);
    end
    tests_run++;
    if (res_stable_o[d] !== e.stable) begin
      tests_failed++;
      $display("FAIL %s_stable: got %b want %b", name, res_stable_o[d], e.stable);
    end
    $display("[TB] %s: pattern=%h gens=%0d stable=%b", name, res_pattern_o[d], res_gens_o[d],
             res_stable_o[d]);
  endtask

  task automatic run(input int d, input logic [15:0] pat, input logic [15:0] gens,
                     input logic [15:0] ep, input logic [15:0] eg, input logic es,
                     input string name, input int exp_lat);
    int  cycles;
    bit  ok;
    start_cfg(d, pat, gens, ep, eg, es);
    wait_valid(d, cycles, ok);
    if (!ok) begin
      void'(sbq.pop_front());
      return;
    end
    check_result(d, name);
    if (exp_lat >= 0) begin
      tests_run++;
      if (cycles != exp_lat) begin
        tests_failed++;
        $display("FAIL %s_latency: got %0d want %0d", name, cycles, exp_lat);
      end
    end
    res_ready[d] = 1'b1;
    @(posedge clk);
    #1 res_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (cfg_ready_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || res_valid_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: cfg_ready=%b busy=%b res_valid=%b want 1 0 0",
               cfg_ready_o[0], busy_o[0], res_valid_o[0]);
    end
    tests_run++;
    if (step_o[0] !== 1'b0 || we_o[0] !== 1'b0 || val_o[0] !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_tile: step=%b we=%b val=%h want 0 0 0000", step_o[0], we_o[0], val_o[0]);
    end
    tests_run++;
    if (res_pattern_o[0] !== 16'h0 || res_gens_o[0] !== 16'h0 || res_stable_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_result: pattern=%h gens=%0d stable=%b want 0000 0 0",
               res_pattern_o[0], res_gens_o[0], res_stable_o[0]);
    end
    reset = 1'b0;
  endtask

  task automatic test_blinker();
    run(0, 16'h0070, 16'd1, 16'h0222, 16'd1, 1'b0, "blinker_g1", 6);
    run(0, 16'h0070, 16'd2, 16'h0070, 16'd2, 1'b0, "blinker_g2", 9);
    run(0, 16'h0001, 16'd1, 16'h0000, 16'd1, 1'b0, "single_cell", -1);
    run(0, 16'hBEEF, 16'd0, 16'hBEEF, 16'd0, 1'b0, "zero_gens", 3);
  endtask

  task automatic test_torus();
    run(1, 16'h000B, 16'd1, 16'h1011, 16'd1, 1'b0, "torus_blinker", 6);
    // Tile 1 now holds 0x1011 (cells 0, 4, 12).
    @(negedge clk);
    tests_run++;
    if (n_o[1] !== 4'b0000 || s_o[1] !== 4'b1011 || w_o[1] !== 4'b0001 || e_o[1] !== 4'b0001) begin
      tests_failed++;
      $display("FAIL torus_edges: n=%b s=%b w=%b e=%b want 0000 1011 0001 0001",
               n_o[1], s_o[1], w_o[1], e_o[1]);
    end
    tests_run++;
    if ({nw_o[1], ne_o[1], sw_o[1], se_o[1]} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL torus_corners: nw ne sw se=%b want 0011", {nw_o[1], ne_o[1], sw_o[1], se_o[1]});
    end
    // Tile 0 holds 0xBEEF but has a dead border.
    tests_run++;
    if ({n_o[0], e_o[0], s_o[0], w_o[0], nw_o[0], ne_o[0], sw_o[0], se_o[0]} !== 20'h0) begin
      tests_failed++;
      $display("FAIL dead_border: got %h want 00000",
               {n_o[0], e_o[0], s_o[0], w_o[0], nw_o[0], ne_o[0], sw_o[0], se_o[0]});
    end
  endtask

  task automatic test_stable();
`ifdef STABLE_STOP_EN
    run(0, 16'h0660, 16'd10, 16'h0660, 16'd1, 1'b1, "block_stable", 6);
`else
    run(0, 16'h0660, 16'd10, 16'h0660, 16'd10, 1'b0, "block_stable", 33);
`endif
  endtask

  task automatic test_hold();
    int cycles;
    bit ok;
    start_cfg(0, 16'h0070, 16'd1, 16'h0222, 16'd1, 1'b0);
    wait_valid(0, cycles, ok);
    if (!ok) begin
      void'(sbq.pop_front());
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (res_valid_o[0] !== 1'b1 || res_pattern_o[0] !== 16'h0222 || res_gens_o[0] !== 16'd1 ||
          cfg_ready_o[0] !== 1'b0 || busy_o[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL hold_cycle%0d: valid=%b pattern=%h gens=%0d cfg_ready=%b busy=%b want 1 0222 1 0 1",
                 i, res_valid_o[0], res_pattern_o[0], res_gens_o[0], cfg_ready_o[0], busy_o[0]);
      end
    end
    check_result(0, "hold");
    res_ready[0] = 1'b1;
    @(posedge clk);
    #1 res_ready[0] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (cfg_ready_o[0] !== 1'b1 || res_valid_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_release: cfg_ready=%b res_valid=%b want 1 0", cfg_ready_o[0], res_valid_o[0]);
    end
  endtask

  task automatic test_reset_midrun();
    bit found = 1'b0;
    start_cfg(0, 16'h0070, 16'd5, 16'h0070, 16'd5, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (step_o[0] === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL midrun_step_seen: arr_step never rose within 50 cycles");
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (cfg_ready_o[0] !== 1'b1 || res_valid_o[0] !== 1'b0 || step_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrun_reset: cfg_ready=%b res_valid=%b step=%b busy=%b want 1 0 0 0",
               cfg_ready_o[0], res_valid_o[0], step_o[0], busy_o[0]);
    end
    reset = 1'b0;
    sbq.delete();
    run(0, 16'h0070, 16'd1, 16'h0222, 16'd1, 1'b0, "after_reset", 6);
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit ok;
    // res_ready held high the whole time, including outside DONE.
    res_ready[0] = 1'b1;
    start_cfg(0, 16'h0070, 16'd1, 16'h0222, 16'd1, 1'b0);
    wait_valid(0, cycles, ok);
    if (ok) check_result(0, "b2b_first");
    else void'(sbq.pop_front());
    @(posedge clk);
    start_cfg(0, 16'h0070, 16'd2, 16'h0070, 16'd2, 1'b0);
    wait_valid(0, cycles, ok);
    if (ok) check_result(0, "b2b_second");
    else void'(sbq.pop_front());
    @(posedge clk);
    #1 res_ready[0] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cfg_valid[d]   = 1'b0;
      cfg_pattern[d] = '0;
      cfg_gens[d]    = '0;
      res_ready[d]   = 1'b0;
    end
    test_reset();
    test_blinker();
    test_torus();
    test_stable();
    test_hold();
    test_reset_midrun();
    test_back_to_back();
    repeat (2) @(posedge clk);
    tests_run++;
    if (step_viol !== 0) begin
      tests_failed++;
      $display("FAIL step_rules: %0d violations want 0", step_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
